// File: rtl/mips_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_multicycle                                           |
// | Brief    : Multicycle MIPS subset core (R-type ALU, lw, sw, beq,     |
// |            bne, addi, j) on a unified req/ready memory port.        |
// | Options  : MIPS_JAL_EN - when defined, opcode 03h executes as jal.  |
// | Revision : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module mips_multicycle #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire
);

  // Opcodes and R-type function codes
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
`ifdef MIPS_JAL_EN
  localparam logic [5:0] c_op_jal   = 6'h03;
`endif
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_slt   = 6'h2A;

  // The wait bound is informational only; the core waits indefinitely.
  localparam int c_unused_wait_max = MEM_WAIT_MAX;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_mdr;
  logic [31:0] r_regs [32];

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_simm;
  logic        w_funct_ok;
  logic        w_taken;
  logic [31:0] w_alu;

  // Raw FSM outputs before reset gating
  logic        w_req;
  logic        w_we;
  logic [31:0] w_addr;
  logic        w_retire;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  // Shift amount field is not used by any supported instruction.
  logic        w_unused_ok;

  assign w_op        = r_ir[31:26];
  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_funct     = r_ir[5:0];
  assign w_simm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_unused_ok = &{1'b0, r_ir[10:6]};

  assign w_funct_ok = (w_funct == c_fn_add) || (w_funct == c_fn_sub) ||
                      (w_funct == c_fn_and) || (w_funct == c_fn_or)  ||
                      (w_funct == c_fn_slt);

  // beq and bne share the BRANCH state; the opcode selects the sense.
  assign w_taken = (w_op == c_op_beq) ? (r_a == r_b) : (r_a != r_b);

  // R-type ALU on the latched operands
  always_comb begin
    w_alu = 32'h0;
    case (w_funct)
      c_fn_add: w_alu = r_a + r_b;
      c_fn_sub: w_alu = r_a - r_b;
      c_fn_and: w_alu = r_a & r_b;
      c_fn_or:  w_alu = r_a | r_b;
      c_fn_slt: w_alu = {31'h0, ($signed(r_a) < $signed(r_b))};
      default:  w_alu = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_pc;
    w_retire    = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_waddr  = 5'd0;
    w_rf_wdata  = r_aluout;
    case (r_state)
      FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (mem_ready) begin
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        case (w_op)
          c_op_rtype: begin
            if (w_funct_ok) begin
              w_state_nxt = EXEC;
            end else begin
              w_retire    = 1'b1;
              w_state_nxt = FETCH;
            end
          end
          c_op_lw, c_op_sw:   w_state_nxt = MEMADR;
          c_op_beq, c_op_bne: w_state_nxt = BRANCH;
          c_op_addi:          w_state_nxt = ADDIEX;
          c_op_j:             w_state_nxt = JUMP;
`ifdef MIPS_JAL_EN
          c_op_jal:           w_state_nxt = JUMP;
`endif
          default: begin
            w_retire    = 1'b1;
            w_state_nxt = FETCH;
          end
        endcase
      end
      MEMADR: begin
        w_state_nxt = (w_op == c_op_lw) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_req  = 1'b1;
        w_addr = r_aluout;
        if (mem_ready) begin
          w_state_nxt = MEMWB;
        end
      end
      MEMWB: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = w_rt;
        w_rf_wdata  = r_mdr;
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      MEMWR: begin
        w_req  = 1'b1;
        w_we   = 1'b1;
        w_addr = r_aluout;
        if (mem_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      EXEC: begin
        w_state_nxt = ALUWB;
      end
      ALUWB: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = w_rd;
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      ADDIEX: begin
        w_state_nxt = ADDIWB;
      end
      ADDIWB: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = w_rt;
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      BRANCH: begin
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      JUMP: begin
`ifdef MIPS_JAL_EN
        // jal links the already-incremented pc into $31
        if (w_op == c_op_jal) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = 5'd31;
          w_rf_wdata = r_pc;
        end
`endif
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result, memory data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'h0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_aluout <= 32'h0;
      r_mdr    <= 32'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        DECODE: begin
          r_a      <= r_regs[w_rs];
          r_b      <= r_regs[w_rt];
          r_aluout <= r_pc + {w_simm[29:0], 2'b00};
        end
        MEMADR: begin
          r_aluout <= r_a + w_simm;
        end
        MEMRD: begin
          if (mem_ready) begin
            r_mdr <= mem_rdata;
          end
        end
        EXEC: begin
          r_aluout <= w_alu;
        end
        ADDIEX: begin
          r_aluout <= r_a + w_simm;
        end
        BRANCH: begin
          if (w_taken) begin
            r_pc <= r_aluout;
          end
        end
        JUMP: begin
          r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        default: begin
        end
      endcase
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Reset forces the bus idle at once, independent of the state register.
  assign mem_req   = w_req & reset;
  assign mem_we    = w_we & reset;
  assign retire    = w_retire & reset;
  assign mem_addr  = w_addr;
  assign mem_wdata = r_b;
  assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mips_multicycle                                        |
// | Brief    : Self-checking bench for mips_multicycle; an instruction-  |
// |            level reference model predicts every bus transaction,    |
// |            retire latency and register/memory effect.               |
// | Options  : MIPS_JAL_EN - must match the RTL build.                  |
// | Revision : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_mips_multicycle;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic [31:0] pc;
  logic        retire;

  // 4 KB unified memory; all addresses alias onto it by bits [11:2]
  logic [31:0] mem [1024];
  assign mem_rdata = mem[mem_addr[11:2]];

  always #5 clk = ~clk;

  mips_multicycle #(
    .RESET_PC     (c_reset_pc),
    .MEM_WAIT_MAX (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  int          phase;      // 0 expect fetch, 1 expect data access, 2 expect retire
  int          base_lat;
  int          stalls;
  int          cyc;
  int          retired;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] next_pc;
  int          wreg;
  logic [31:0] wval;
  logic        hold_write = 1'b0;
  logic        prev_stall;
  logic        p_we;
  logic [31:0] p_addr, p_wdata, p_pc;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpc        = c_reset_pc;
    phase      = 0;
    stalls     = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    wreg       = 0;
  endtask

  // Architectural effect of one instruction, from the ISA definition.
  task automatic model_decode(input logic [31:0] w);
    logic [31:0] a, b, simm, p4;
    logic [5:0]  op, fn;
    op   = w[31:26];
    fn   = w[5:0];
    a    = mregs[w[25:21]];
    b    = mregs[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    p4   = mpc + 32'd4;
    next_pc  = p4;
    wreg     = 0;
    wval     = 32'h0;
    phase    = 2;
    base_lat = 2;
    exp_we   = 1'b0;
    case (op)
      6'h00: begin
        base_lat = 4;
        wreg     = w[15:11];
        case (fn)
          6'h20: wval = a + b;
          6'h22: wval = a - b;
          6'h24: wval = a & b;
          6'h25: wval = a | b;
          6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin base_lat = 2; wreg = 0; end
        endcase
      end
      6'h08: begin base_lat = 4; wreg = w[20:16]; wval = a + simm; end
      6'h23: begin base_lat = 5; wreg = w[20:16]; phase = 1; exp_addr = a + simm; end
      6'h2B: begin
        base_lat = 4; phase = 1; exp_we = 1'b1; exp_addr = a + simm; exp_wdata = b;
      end
      6'h04: begin base_lat = 3; if (a == b) next_pc = p4 + (simm << 2); end
      6'h05: begin base_lat = 3; if (a != b) next_pc = p4 + (simm << 2); end
      6'h02: begin base_lat = 3; next_pc = {p4[31:28], w[25:0], 2'b00}; end
`ifdef MIPS_JAL_EN
      6'h03: begin
        base_lat = 3; next_pc = {p4[31:28], w[25:0], 2'b00}; wreg = 31; wval = p4;
      end
`endif
      default: base_lat = 2;
    endcase
  endtask

  // One clock of stimulus and checking, sampled away from the rising edge.
  task automatic cycle_check();
    @(negedge clk);
    #1;
    if (hold_write && mem_req && mem_we) mem_ready = 1'b0;
    else mem_ready = ($urandom_range(0, 3) != 0);
    #1;
    cyc++;
    if (prev_stall) begin
      chk("stall_req", mem_req, 1'b1);
      chk("stall_we", mem_we, p_we);
      chk("stall_addr", mem_addr, p_addr);
      chk("stall_wdata", mem_wdata, p_wdata);
      chk("stall_pc", pc, p_pc);
    end
    if (mem_req && !mem_ready) stalls++;
    if (mem_req && mem_ready) begin
      if (phase == 0) begin
        chk("fetch_we", mem_we, 1'b0);
        chk("fetch_addr", mem_addr, mpc);
        chk("fetch_pc", pc, mpc);
        model_decode(mem[mpc[11:2]]);
      end else if (phase == 1) begin
        chk("data_we", mem_we, exp_we);
        chk("data_addr", mem_addr, exp_addr);
        if (exp_we) begin
          chk("store_data", mem_wdata, exp_wdata);
          mem[exp_addr[11:2]] = exp_wdata;
        end else begin
          wval = mem[exp_addr[11:2]];
        end
        phase = 2;
      end else begin
        chk("access_phase", phase, 1);
      end
    end
    if (retire) begin
      chk("retire_phase", phase, 2);
      chk("latency", cyc, base_lat + stalls);
      if (wreg != 0) mregs[wreg] = wval;
      mpc     = next_pc;
      phase   = 0;
      cyc     = 0;
      stalls  = 0;
      retired++;
    end
    if (cyc > 200) begin
      chk("retire_timeout", cyc, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    prev_stall = mem_req && !mem_ready;
    p_we       = mem_we;
    p_addr     = mem_addr;
    p_wdata    = mem_wdata;
    p_pc       = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    int          k;
    rs = 5'($urandom_range(0, 7)); if (rs == 5'd7) rs = 5'd31;
    rt = 5'($urandom_range(0, 7)); if (rt == 5'd7) rt = 5'd31;
    rd = 5'($urandom_range(0, 7));
    k  = $urandom_range(0, 15);
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      default: fn = 6'h3F;
    endcase
    case (k)
      0, 1, 2, 3, 4, 5: w = {6'h00, rs, rt, rd, 5'd0, fn};
      6, 7:   w = {6'h08, rs, rt, 16'($urandom)};
      8, 9:   w = {6'h23, rs, rt, 16'($urandom)};
      10, 11: w = {6'h2B, rs, rt, 16'($urandom)};
      12:     w = {6'h04, rs, rt, 16'($urandom_range(0, 16) - 8)};
      13:     w = {6'h05, rs, rt, 16'($urandom_range(0, 16) - 8)};
      14:     w = {6'h02, 26'($urandom_range(0, 1023))};
      default: w = ($urandom_range(0, 1) != 0) ? {6'h03, 26'($urandom_range(0, 1023))}
                                               : {6'h3F, rs, rt, 16'($urandom)};
    endcase
    return w;
  endfunction

  initial begin
    logic seen;
    // Directed program
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]  = 32'h2001_0005;  // 00 addi $1,$0,5
    mem[1]  = 32'h0021_1020;  // 04 add  $2,$1,$1
    mem[2]  = 32'hAC02_0100;  // 08 sw   $2,0x100($0)
    mem[3]  = 32'h8C03_0104;  // 0C lw   $3,0x104($0)
    mem[4]  = 32'h1000_0001;  // 10 beq  $0,$0,+1 -> 0x18
    mem[5]  = 32'h2005_0001;  // 14 addi $5,$0,1 (skipped)
    mem[6]  = 32'h1400_0001;  // 18 bne  $0,$0,+1 (not taken)
    mem[7]  = 32'h2000_0007;  // 1C addi $0,$0,7
    mem[8]  = 32'hAC03_0108;  // 20 sw   $3,0x108($0)
    mem[9]  = 32'hAC00_010C;  // 24 sw   $0,0x10C($0)
    mem[10] = 32'hAC05_0110;  // 28 sw   $5,0x110($0)
    mem[11] = 32'h0C00_0034;  // 2C jal  0xD0 (unknown when jal disabled)
    mem[12] = 32'hAC1F_0114;  // 30 sw   $31,0x114($0)
    mem[13] = 32'hAC01_0118;  // 34 sw   $1,0x118($0)
    mem[52] = 32'hAC1F_0114;  // D0 sw   $31,0x114($0)
    mem[53] = 32'hAC01_0118;  // D4 sw   $1,0x118($0)
    mem[65] = 32'hDEAD_BEEF;  // data at 0x104

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_pc", pc, c_reset_pc);

    @(posedge clk);
    #2 reset = 1'b1;
    retired = 0;
    for (int i = 0; i < 400 && retired < 12; i++) cycle_check();
    chk("dir_retired", retired, 12);
    chk("dir_add_result", mem[64], 32'd10);
    chk("dir_lw_result", mem[66], 32'hDEAD_BEEF);
    chk("dir_r0_result", mem[67], 32'h0);
    chk("dir_skip_result", mem[68], 32'h0);
`ifdef MIPS_JAL_EN
    chk("dir_jal_link", mem[69], 32'h0000_0030);
`else
    chk("dir_jal_link", mem[69], 32'h0);
`endif

    // Abort a stalled store with reset
    hold_write = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle_check();
      if (mem_req && mem_we) seen = 1'b1;
    end
    chk("reached_store", seen, 1'b1);
    chk("store_addr_pending", mem_addr, 32'h0000_0118);
    reset = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_retire", retire, 1'b0);
    chk("abort_pc", pc, c_reset_pc);
    hold_write = 1'b0;
    repeat (2) @(posedge clk);
    chk("abort_no_write", mem[70], 32'h0);

    // Randomised program from reset
    for (int i = 0; i < 1024; i++) mem[i] = rand_instr();
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    retired = 0;
    for (int i = 0; i < 30000 && retired < 500; i++) cycle_check();
    chk("rand_retired", retired, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
